// File: rtl/hazard_ctrl.sv
// Pipeline hazard/stall controller: load-use stall, taken-branch flush, data-memory wait freeze.
// Optional performance counters (stall_cnt, flush_cnt) are enabled by defining HAZARD_PERF_EN.
module hazard_ctrl #(
  parameter int unsigned ASIZE      = 5,
  parameter int unsigned BR_PENALTY = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [ASIZE-1:0] rs_IF_ID,
  input  logic [ASIZE-1:0] rt_IF_ID,
  input  logic [ASIZE-1:0] rt_ID_EXE,
  input  logic             memread_ID_EXE,
  input  logic             branch_taken,
  input  logic             mem_req_EXE_MEM,
  input  logic             mem_ready,
  input  logic             perf_clr,
  output logic             pc_wen,
  output logic             if_id_wen,
  output logic             exe_mem_wen,
  output logic             id_exe_bubble,
  output logic             if_id_flush,
  output logic             id_exe_flush,
  output logic             mem_wb_bubble,
  output logic [1:0]       ctrl_state,
  output logic [15:0]      stall_cnt,
  output logic [15:0]      flush_cnt
);

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    LU_STALL = 2'b01,
    MEM_WAIT = 2'b10,
    FLUSH    = 2'b11
  } state_e;

  localparam logic [1:0] FCNT_LOAD = 2'(BR_PENALTY - 1);

  state_e     state_q, state_d;
  logic [1:0] fcnt_q, fcnt_d;
  logic       mem_wait, lu_hazard, br_accept;
  logic       pc_wen_c, if_id_wen_c, exe_mem_wen_c, id_exe_bubble_c;
  logic       if_id_flush_c, id_exe_flush_c, mem_wb_bubble_c;

  assign mem_wait  = mem_req_EXE_MEM && !mem_ready;
  assign lu_hazard = memread_ID_EXE && (rt_ID_EXE != '0) &&
                     ((rt_ID_EXE == rs_IF_ID) || (rt_ID_EXE == rt_IF_ID));

  always_comb begin
    state_d         = RUN;
    fcnt_d          = fcnt_q;
    br_accept       = 1'b0;
    pc_wen_c        = 1'b1;
    if_id_wen_c     = 1'b1;
    exe_mem_wen_c   = 1'b1;
    id_exe_bubble_c = 1'b0;
    if_id_flush_c   = 1'b0;
    id_exe_flush_c  = 1'b0;
    mem_wb_bubble_c = 1'b0;
    if (mem_wait) begin
      pc_wen_c        = 1'b0;
      if_id_wen_c     = 1'b0;
      exe_mem_wen_c   = 1'b0;
      mem_wb_bubble_c = 1'b1;
      state_d         = MEM_WAIT;
    end else if (branch_taken && (state_q != MEM_WAIT)) begin
      br_accept      = 1'b1;
      if_id_flush_c  = 1'b1;
      id_exe_flush_c = 1'b1;
      fcnt_d         = FCNT_LOAD;
      if (BR_PENALTY > 1) state_d = FLUSH;
    end else begin
      unique case (state_q)
        FLUSH: begin
          if_id_flush_c = 1'b1;
          if (fcnt_q != '0) fcnt_d = fcnt_q - 2'd1;
          // leave FLUSH on the cycle the counter is decremented to zero
          if (fcnt_q > 2'd1) state_d = FLUSH;
        end
        RUN: begin
          if (lu_hazard) begin
            pc_wen_c        = 1'b0;
            if_id_wen_c     = 1'b0;
            id_exe_bubble_c = 1'b1;
            state_d         = LU_STALL;
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RUN;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
    end
  end

  assign pc_wen        = pc_wen_c        & rst;
  assign if_id_wen     = if_id_wen_c     & rst;
  assign exe_mem_wen   = exe_mem_wen_c   & rst;
  assign id_exe_bubble = id_exe_bubble_c & rst;
  assign if_id_flush   = if_id_flush_c   & rst;
  assign id_exe_flush  = id_exe_flush_c  & rst;
  assign mem_wb_bubble = mem_wb_bubble_c & rst;
  assign ctrl_state    = state_q;

`ifdef HAZARD_PERF_EN
  logic [15:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (perf_clr) begin
      stall_cnt_d = '0;
      flush_cnt_d = '0;
    end else begin
      if (!pc_wen_c && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 16'd1;
      if (br_accept && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  logic unused_perf;
  assign unused_perf = perf_clr ^ br_accept;
  assign stall_cnt   = '0;
  assign flush_cnt   = '0;
`endif

endmodule
